// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: instruction fetch (port 0,
// read-only) and data access (port 1, read/write) with a fixed-latency access.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2,
  parameter int FIX_PRI = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [DATA_W-1:0] addr0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [DATA_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sel_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: req is a level held until gnt pulses; a req still high in the
  // cycle after gnt (or in RESP) is treated as a new request. done pulses once
  // per access, and rdata_o is valid from that cycle until the next read ends.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

  state_t        state, state_n;
  logic [CW-1:0] counter;
  logic          last_winner;
  logic          win;
  logic          take;
  logic          last_cycle;

  always_comb begin
    state_n = state;
    take    = 1'b0;
    win     = req1_i;
    if (req0_i && req1_i) begin
      win = (FIX_PRI != 0) ? 1'b1 : ~last_winner;
    end
    case (state)
      IDLE: begin
        if (req0_i || req1_i) begin
          take    = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (counter == '0) state_n = RESP;
      end
      RESP: begin
        // Back-to-back: a request seen here starts the next access directly.
        if (req0_i || req1_i) begin
          take    = 1'b1;
          state_n = ACCESS;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign last_cycle = (state == ACCESS) && (counter == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      counter     <= '0;
      last_winner <= 1'b1;
      sel_o       <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      gnt0_o      <= 1'b0;
      gnt1_o      <= 1'b0;
      done0_o     <= 1'b0;
      done1_o     <= 1'b0;
    end else begin
      state   <= state_n;
      gnt0_o  <= take & ~win;
      gnt1_o  <= take & win;
      done0_o <= last_cycle & ~sel_o;
      done1_o <= last_cycle & sel_o;
      if (take) begin
        sel_o       <= win;
        last_winner <= win;
        mem_addr_o  <= win ? addr1_i : addr0_i;
        mem_we_o    <= win & we1_i;
        mem_wdata_o <= wdata1_i;
        counter     <= LAT_M1;
      end else if (state == ACCESS && counter != '0) begin
        counter <= counter - 1'b1;
      end
      if (last_cycle && !mem_we_o) begin
        rdata_o <= mem_rdata_i;
      end
    end
  end

  assign mem_en_o    = (state == ACCESS);
  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin instance (a) and one
// fixed-priority instance (b), both MEM_LAT=2.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_i;
  logic        req0, req1, we1;
  logic        req0_b, req1_b;
  logic [31:0] addr0, addr1, wdata1, mem_rdata;

  logic        gnt0, gnt1, done0, done1, sel, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  dbg_state;

  logic        gnt0_b, gnt1_b, done0_b, done1_b, sel_b, mem_en_b, mem_we_b, busy_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
  logic [1:0]  dbg_state_b;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.DATA_W(32), .MEM_LAT(2), .FIX_PRI(0)) dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .req0_i(req0), .addr0_i(addr0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
    .rdata_o(rdata), .sel_o(sel), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  mem_port_arbiter #(.DATA_W(32), .MEM_LAT(2), .FIX_PRI(1)) dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .req0_i(req0_b), .addr0_i(addr0),
    .req1_i(req1_b), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0_b), .gnt1_o(gnt1_b), .done0_o(done0_b), .done1_o(done1_b),
    .rdata_o(rdata_b), .sel_o(sel_b), .mem_en_o(mem_en_b), .mem_we_o(mem_we_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata),
    .busy_o(busy_b), .dbg_state_o(dbg_state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; req0 = 0; req1 = 0; we1 = 0; req0_b = 0; req1_b = 0;
    addr0 = 0; addr1 = 0; wdata1 = 0; mem_rdata = 0;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_gnt", {gnt0, gnt1, done0, done1}, 0);
    rst_i = 1'b1;

    // Single fetch
    req0 = 1; addr0 = 32'h0000_0010; mem_rdata = 32'h2002_0005;
    tick();
    chk("f_gnt0", gnt0, 1);
    chk("f_gnt1", gnt1, 0);
    chk("f_en1", mem_en, 1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_sel", sel, 0);
    req0 = 0;
    tick();
    chk("f_gnt0_off", gnt0, 0);
    chk("f_en2", mem_en, 1);
    tick();
    chk("f_done0", done0, 1);
    chk("f_done1", done1, 0);
    chk("f_rdata", rdata, 32'h2002_0005);
    chk("f_en3", mem_en, 0);
    tick();
    chk("f_idle", busy, 0);
    chk("f_done_off", done0, 0);

    // Data write
    req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678;
    tick();
    chk("w_gnt1", gnt1, 1);
    chk("w_sel", sel, 1);
    chk("w_we", mem_we, 1);
    chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w_addr", mem_addr, 32'h40);
    req1 = 0;
    tick();
    chk("w_en2", mem_en, 1);
    chk("w_we2", mem_we, 1);
    tick();
    chk("w_done1", done1, 1);
    chk("w_done0", done0, 0);
    chk("w_rdata_hold", rdata, 32'h2002_0005);
    tick();
    chk("w_idle", busy, 0);

    // Round-robin tie: last winner was 1, so order is 0,1,0,1
    req0 = 1; req1 = 1; we1 = 0; addr0 = 32'h30; addr1 = 32'h80;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = 32'h100 + k;
      tick();
      chk("rr_gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", gnt1, (k % 2 == 1) ? 1 : 0);
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h30 : 32'h80);
      chk("rr_busy_a", busy, 1);
      tick();
      chk("rr_en", mem_en, 1);
      tick();
      chk("rr_done", {done1, done0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_rdata", rdata, 32'h100 + k);
      chk("rr_busy_r", busy, 1);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    tick();
    chk("rr_idle", busy, 0);

    // Fixed priority on instance b: requester 1 keeps winning
    req0_b = 1; req1_b = 1; we1 = 0; addr0 = 32'h50; addr1 = 32'h60;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("fp_gnt1", gnt1_b, 1);
      chk("fp_gnt0", gnt0_b, 0);
      tick();
      chk("fp_gnt0_mid", gnt0_b, 0);
      tick();
      chk("fp_done1", done1_b, 1);
      if (k == 1) req1_b = 0;
    end
    tick();
    chk("fp_late_gnt0", gnt0_b, 1);
    chk("fp_late_addr", mem_addr_b, 32'h50);
    req0_b = 0;
    tick(); tick();
    chk("fp_done0", done0_b, 1);
    tick();
    chk("fp_idle", busy_b, 0);

    // Address change during ACCESS is ignored
    req0 = 1; addr0 = 32'h10;
    tick();
    chk("ic_gnt0", gnt0, 1);
    addr0 = 32'h20; req0 = 0;
    tick();
    chk("ic_addr", mem_addr, 32'h10);
    tick();
    chk("ic_done", done0, 1);
    tick();

    // Reset in the second ACCESS cycle; last_winner is 0 beforehand
    req0 = 1; addr0 = 32'h70;
    tick();
    chk("ra_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    chk("ra_en", mem_en, 1);
    rst_i = 1'b0;
    #1;
    chk("ra_en0", mem_en, 0);
    chk("ra_busy0", busy, 0);
    chk("ra_state", dbg_state, 0);
    chk("ra_addr0", mem_addr, 0);
    chk("ra_wdata0", mem_wdata, 0);
    chk("ra_rdata0", rdata, 0);
    chk("ra_misc0", {gnt0, gnt1, done0, done1, sel, mem_we}, 0);
    tick();
    chk("ra_nodone", {done0, done1}, 0);
    rst_i = 1'b1;
    req0 = 1; req1 = 1; addr0 = 32'h90; addr1 = 32'hA0;
    tick();
    chk("ra_tie_gnt0", gnt0, 1);
    chk("ra_tie_gnt1", gnt1, 0);
    chk("ra_tie_addr", mem_addr, 32'h90);
    req0 = 0; req1 = 0;
    tick(); tick();
    chk("ra_tie_done0", done0, 1);
    tick();
    chk("ra_tie_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two requesters:
  - requester 0: instruction fetch, read-only.
  - requester 1: data access, read/write.
- Arbitrates between them and latches the winner's address, write enable and write data.
- Drives the address/data mux select.
- Sequences the fixed-latency memory access and returns read data with a one-cycle done pulse.

Parameters:
- DATA_W, 32, data and address width.
- MEM_LAT, 2, cycles mem_en_o is held per access; must be >= 1.
- FIX_PRI, 0, 0 = round-robin; 1 = requester 1 always wins ties.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-low reset.
- req0_i  input  1  fetch request; level-sensitive.
- addr0_i  input  DATA_W  fetch address.
- req1_i  input  1  data request; level-sensitive.
- we1_i  input  1  1 = write, 0 = read.
- addr1_i  input  DATA_W  data address.
- wdata1_i  input  DATA_W  write data.
- gnt0_o  output  1  one-cycle grant pulse to requester 0.
- gnt1_o  output  1  one-cycle grant pulse to requester 1.
- done0_o  output  1  one-cycle completion pulse to requester 0.
- done1_o  output  1  one-cycle completion pulse to requester 1.
- rdata_o  output  DATA_W  last captured read data.
- sel_o  output  1  mux select, 0 = requester 0, 1 = requester 1.
- mem_en_o  output  1  memory enable.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  DATA_W  latched memory address.
- mem_wdata_o  output  DATA_W  latched memory write data.
- mem_rdata_i  input  DATA_W  memory read data, valid in the last ACCESS cycle.
- busy_o  output  1  1 when state != IDLE.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - rst_i is asynchronous and active-low.
  - All state is updated on the rising edge of clk_i.
- Reset values:
  - state = IDLE, counter = 0, last_winner = 1.
  - All outputs 0: gnt*, done*, sel_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, busy_o.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration:
  - Evaluated at the clock edge while the state is IDLE or RESP.
  - Only one request high: that requester wins.
  - Both high, FIX_PRI=0: the winner is ~last_winner, so requester 0 wins the first tie after reset.
  - Both high, FIX_PRI=1: requester 1 wins.
  - On a win, latch the following and go to ACCESS:
    - sel_o and last_winner = winner.
    - mem_addr_o = winner's address.
    - mem_we_o = we1_i if requester 1 won, else 0.
    - mem_wdata_o = wdata1_i.
    - counter = MEM_LAT-1.
- ACCESS:
  - mem_en_o = 1.
  - gnt<winner>_o = 1 in the first ACCESS cycle only.
  - Address, data and request inputs are ignored.
  - counter decrements each cycle.
  - At the edge where counter == 0: if it is a read, rdata_o <= mem_rdata_i; go to RESP.
  - mem_en_o stays high for exactly MEM_LAT cycles.
- RESP:
  - done<winner>_o = 1 for one cycle; mem_en_o = 0.
  - Requests sampled here are new requests, so back-to-back ACCESS is allowed with no IDLE cycle.
  - With no request pending, go to IDLE.
- Requester rule: deassert req the cycle after gnt unless a further access is wanted.
- Latency: a request sampled at edge N gives:
  - gnt in cycle N+1.
  - ACCESS in cycles N+1 .. N+MEM_LAT.
  - done and valid rdata in cycle N+MEM_LAT+1.
- Hold behaviour:
  - rdata_o holds its value until the next read completes; writes never change it.
  - sel_o, mem_addr_o and mem_we_o hold their last values outside ACCESS; mem_en_o gates their use.
- MEM_LAT=1: ACCESS lasts one cycle, and gnt and mem_en_o coincide.
- Reset mid-access: go to IDLE immediately and reset all outputs. The in-flight access is abandoned and no done pulse is issued.
- gnt0_o/gnt1_o and done0_o/done1_o are never high in the same cycle.

Test Plan:
- Single fetch, MEM_LAT=2:
  - Stimulus: req0_i=1, addr0_i=0x0000_0010; memory returns 0x2002_0005.
  - Expect: gnt0_o in cycle 1; mem_en_o in cycles 1-2 with mem_addr_o=0x10 and sel_o=0.
  - Expect: done0_o in cycle 3 with rdata_o=0x2002_0005.
- Data write:
  - Stimulus: req1_i=1, we1_i=1, addr1_i=0x40, wdata1_i=0xDEAD_BEEF.
  - Expect: sel_o=1, mem_we_o=1, mem_wdata_o=0xDEAD_BEEF for 2 cycles, then done1_o.
  - Expect: rdata_o keeps its previous value.
- Tie, round-robin:
  - Stimulus: req0_i and req1_i both held high for 4 accesses.
  - Expect: grant order 0,1,0,1; every access back-to-back with no IDLE cycle; busy_o stays 1.
- FIX_PRI=1, both requests held:
  - Expect: requester 1 always granted; gnt0_o never asserts until req1_i drops.
- Input change during ACCESS:
  - Stimulus: change addr0_i from 0x10 to 0x20 in the first ACCESS cycle.
  - Expect: mem_addr_o stays 0x10.
- Reset mid-access:
  - Stimulus: drive rst_i=0 in the second ACCESS cycle.
  - Expect: all outputs 0 immediately, no done pulse, state IDLE.
  - After release: the first tie goes to requester 0.
